// File: rtl/jtframe_dump_pkg.sv
// Shared types and default widths for the simulation dump trigger.
package jtframe_dump_pkg;

  localparam int unsigned CNTW_DEF = 32;
  localparam int unsigned LENW_DEF = 16;

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } dump_state_e;

endpackage

// File: rtl/jtframe_edge.sv
// Edge detector: registers the input once and flags a fall (FALL=1) or a rise (FALL=0)
// combinationally against the registered copy. The copy clears on reset so that
// reset release never reports an edge.
module jtframe_edge #(
  parameter bit FALL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic edge_c
);

  logic din_l;

  // Previous-cycle copy of the input
  always_ff @(posedge clk) begin
    if (rst) din_l <= 1'b0;
    else     din_l <= din;
  end

  if (FALL) begin : g_fall
    assign edge_c = din_l & ~din;
  end else begin : g_rise
    assign edge_c = ~din_l & din;
  end

endmodule

// File: rtl/jtframe_dump_trigger.sv
// Frame counter and dump-window trigger for the simulation dump hook.
// Optional: JTFRAME_DUMP_AFTER_DL_EN holds the frame counter at 0 during a ROM
// download and only allows the window to open after a download has finished.
module jtframe_dump_trigger
  import jtframe_dump_pkg::*;
#(
  parameter int unsigned CNTW = CNTW_DEF,
  parameter int unsigned LENW = LENW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            vs,
  input  logic            downloading,
  input  logic [CNTW-1:0] start_frame,
  input  logic [LENW-1:0] frame_len,
  input  logic            rearm,
  output logic [CNTW-1:0] frame_cnt,
  output logic            frame_pulse,
  output logic            dl_done,
  output logic            dump_en,
  output logic [LENW-1:0] dump_frames
);

  dump_state_e     state, state_nxt;
  logic            fall_c, dl_fall_c, trig_ok_c, last_c;
  logic [CNTW-1:0] frame_cnt_nxt;
  logic [LENW-1:0] dump_frames_nxt, len_q, len_nxt;
  logic            dump_en_nxt;

  jtframe_edge #(.FALL(1'b1)) u_vs_edge (
    .clk    (clk),
    .rst    (rst),
    .din    (vs),
    .edge_c (fall_c)
  );

  jtframe_edge #(.FALL(1'b1)) u_dl_edge (
    .clk    (clk),
    .rst    (rst),
    .din    (downloading),
    .edge_c (dl_fall_c)
  );

`ifdef JTFRAME_DUMP_AFTER_DL_EN
  logic dl_seen;

  // Remembers that at least one download has completed since reset
  always_ff @(posedge clk) begin
    if (rst)            dl_seen <= 1'b0;
    else if (dl_fall_c) dl_seen <= 1'b1;
  end

  assign trig_ok_c = dl_seen;
`else
  assign trig_ok_c = 1'b1;
`endif

  // The frame closing a finite window is the one that brings the count up to the length
  assign last_c = (len_q != '0) && ((dump_frames + LENW'(1)) == len_q);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ARMED;
    else     state <= state_nxt;
  end

  // Next-state logic; rearm overrides any transition on the same frame
  always_comb begin
    state_nxt = state;
    case (state)
      ARMED:   if (fall_c && trig_ok_c && (frame_cnt == start_frame)) state_nxt = ACTIVE;
      ACTIVE:  if (fall_c && last_c) state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = ARMED;
    endcase
    if (rearm) state_nxt = ARMED;
`ifdef JTFRAME_DUMP_AFTER_DL_EN
    if (downloading) state_nxt = ARMED;
`endif
  end

  // Next values of the registered outputs
  always_comb begin
    frame_cnt_nxt   = frame_cnt;
    dump_frames_nxt = dump_frames;
    len_nxt         = len_q;
    dump_en_nxt     = (state_nxt == ACTIVE);
    if (fall_c) frame_cnt_nxt = frame_cnt + CNTW'(1);
    if ((state == ARMED) && (state_nxt == ACTIVE)) begin
      dump_frames_nxt = '0;
      len_nxt         = frame_len;
    end else if ((state == ACTIVE) && (state_nxt != ARMED) && fall_c && (dump_frames != '1)) begin
      dump_frames_nxt = dump_frames + LENW'(1);
    end
    if (rearm) dump_frames_nxt = '0;
`ifdef JTFRAME_DUMP_AFTER_DL_EN
    if (downloading || dl_fall_c) frame_cnt_nxt = '0;
`endif
  end

  // Output and window-length registers
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt   <= '0;
      frame_pulse <= 1'b0;
      dl_done     <= 1'b0;
      dump_en     <= 1'b0;
      dump_frames <= '0;
      len_q       <= '0;
    end else begin
      frame_cnt   <= frame_cnt_nxt;
      frame_pulse <= fall_c;
      dl_done     <= dl_fall_c;
      dump_en     <= dump_en_nxt;
      dump_frames <= dump_frames_nxt;
      len_q       <= len_nxt;
    end
  end

endmodule

// File: tb/tb_jtframe_dump_trigger.sv
// Self-checking bench for jtframe_dump_trigger (default build).
module tb_jtframe_dump_trigger;

  localparam int M_ARMED  = 0;
  localparam int M_ACTIVE = 1;
  localparam int M_DONE   = 2;

  logic        clk;
  logic        rst, vs, downloading, rearm;
  logic [31:0] start_frame;
  logic [15:0] frame_len;

  logic [31:0] frame_cnt;
  logic        frame_pulse, dl_done, dump_en;
  logic [15:0] dump_frames;

  logic [31:0] s_frame_cnt;
  logic        s_frame_pulse, s_dl_done, s_dump_en;
  logic [3:0]  s_dump_frames;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int          mode;
  bit          p_vs, p_dl;
  logic [31:0] e_cnt;
  logic [15:0] e_frames, m_len;
  bit          e_pulse, e_dl, e_en;

  jtframe_dump_trigger dut (
    .clk         (clk),
    .rst         (rst),
    .vs          (vs),
    .downloading (downloading),
    .start_frame (start_frame),
    .frame_len   (frame_len),
    .rearm       (rearm),
    .frame_cnt   (frame_cnt),
    .frame_pulse (frame_pulse),
    .dl_done     (dl_done),
    .dump_en     (dump_en),
    .dump_frames (dump_frames)
  );

  // narrow length counter so saturation is reachable in a short run
  jtframe_dump_trigger #(.CNTW(32), .LENW(4)) dut_small (
    .clk         (clk),
    .rst         (rst),
    .vs          (vs),
    .downloading (downloading),
    .start_frame (start_frame),
    .frame_len   (frame_len[3:0]),
    .rearm       (rearm),
    .frame_cnt   (s_frame_cnt),
    .frame_pulse (s_frame_pulse),
    .dl_done     (s_dl_done),
    .dump_en     (s_dump_en),
    .dump_frames (s_dump_frames)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vs, rearm, dl;
    logic [31:0] start;
    logic [15:0] len;
    logic [31:0] e_cnt;
    logic        e_pulse, e_en, e_dl;
    logic [15:0] e_frames;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic r, logic d, logic [31:0] s, logic [15:0] l,
                              logic [31:0] c, logic p, logic en, logic dd, logic [15:0] f);
    vec_t x;
    x.vs = v; x.rearm = r; x.dl = d; x.start = s; x.len = l;
    x.e_cnt = c; x.e_pulse = p; x.e_en = en; x.e_dl = dd; x.e_frames = f;
    return x;
  endfunction

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endfunction

  // Event-level model: frames are counted on vs falls, the window opens on the
  // matching frame and closes after frame_len frames.
  task automatic model_update();
    bit fell, dlf;
    fell = p_vs && !vs;
    dlf  = p_dl && !downloading;
    if (rst) begin
      e_cnt = '0; e_pulse = 0; e_dl = 0; e_en = 0; e_frames = '0; m_len = '0;
      mode = M_ARMED; p_vs = 0; p_dl = 0;
    end else begin
      p_vs = vs; p_dl = downloading;
      e_pulse = fell; e_dl = dlf;
      if (rearm) begin
        mode = M_ARMED; e_frames = '0;
      end else if (fell) begin
        if (mode == M_ARMED && e_cnt == start_frame) begin
          mode = M_ACTIVE; e_frames = '0; m_len = frame_len;
        end else if (mode == M_ACTIVE) begin
          if (e_frames != 16'hFFFF) e_frames = e_frames + 16'd1;
          if (m_len != 0 && e_frames == m_len) mode = M_DONE;
        end
      end
      if (fell) e_cnt = e_cnt + 32'd1;
      e_en = (mode == M_ACTIVE);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check("model_frame_cnt",   frame_cnt,   e_cnt);
    check("model_frame_pulse", frame_pulse, e_pulse);
    check("model_dl_done",     dl_done,     e_dl);
    check("model_dump_en",     dump_en,     e_en);
    check("model_dump_frames", dump_frames, e_frames);
  endtask

  initial begin
    rst = 1; vs = 1; downloading = 0; rearm = 0; start_frame = 3; frame_len = 2;
    repeat (4) step();
    rst = 0;
    step();
    check("reset_frame_cnt",   frame_cnt,   0);
    check("reset_frame_pulse", frame_pulse, 0);
    check("reset_dump_en",     dump_en,     0);
    check("reset_dump_frames", dump_frames, 0);

    // vs rst dl start len | cnt pulse en dl_done frames
    tbl.push_back(mk(1,0,0,3,2,  0,0,0,0,0));
    tbl.push_back(mk(0,0,0,3,2,  1,1,0,0,0));
    tbl.push_back(mk(1,0,1,3,2,  1,0,0,0,0));
    tbl.push_back(mk(0,0,0,3,2,  2,1,0,1,0));
    tbl.push_back(mk(1,0,0,3,2,  2,0,0,0,0));
    tbl.push_back(mk(0,0,0,3,2,  3,1,0,0,0));
    tbl.push_back(mk(1,0,0,3,2,  3,0,0,0,0));
    tbl.push_back(mk(0,0,0,3,2,  4,1,1,0,0));
    tbl.push_back(mk(1,0,0,3,2,  4,0,1,0,0));
    tbl.push_back(mk(0,0,0,3,2,  5,1,1,0,1));
    tbl.push_back(mk(1,0,0,3,2,  5,0,1,0,1));
    tbl.push_back(mk(0,0,0,3,2,  6,1,0,0,2));
    tbl.push_back(mk(1,0,0,3,2,  6,0,0,0,2));
    tbl.push_back(mk(0,0,0,3,2,  7,1,0,0,2));
    tbl.push_back(mk(1,0,0,7,2,  7,0,0,0,2));
    tbl.push_back(mk(0,1,0,7,2,  8,1,0,0,0));
    tbl.push_back(mk(1,0,0,8,2,  8,0,0,0,0));
    tbl.push_back(mk(0,0,0,8,2,  9,1,1,0,0));
    tbl.push_back(mk(1,0,0,8,2,  9,0,1,0,0));
    tbl.push_back(mk(0,0,0,8,2, 10,1,1,0,1));

    for (int i = 0; i < tbl.size(); i++) begin
      vs = tbl[i].vs; rearm = tbl[i].rearm; downloading = tbl[i].dl;
      start_frame = tbl[i].start; frame_len = tbl[i].len;
      step();
      check($sformatf("tbl%0d_frame_cnt", i),   frame_cnt,   tbl[i].e_cnt);
      check($sformatf("tbl%0d_frame_pulse", i), frame_pulse, tbl[i].e_pulse);
      check($sformatf("tbl%0d_dump_en", i),     dump_en,     tbl[i].e_en);
      check($sformatf("tbl%0d_dl_done", i),     dl_done,     tbl[i].e_dl);
      check($sformatf("tbl%0d_dump_frames", i), dump_frames, tbl[i].e_frames);
    end
    rearm = 0;

    // reset in the middle of an open window
    vs = 1; rst = 1;
    step();
    check("midrst_frame_cnt",   frame_cnt,   0);
    check("midrst_dump_en",     dump_en,     0);
    check("midrst_dump_frames", dump_frames, 0);
    check("midrst_frame_pulse", frame_pulse, 0);
    rst = 0; vs = 0;
    step();
    check("postrst_no_pulse", frame_pulse, 0);
    start_frame = 0;
    vs = 1; step();
    vs = 0; step();
    check("postrst_rearmed_en",  dump_en,   1);
    check("postrst_rearmed_cnt", frame_cnt, 1);

    // unlimited window with saturating frame count on the narrow instance
    rst = 1; step();
    rst = 0; start_frame = 0; frame_len = 0;
    for (int n = 1; n <= 40; n++) begin
      vs = 1; step();
      vs = 0; step();
      check($sformatf("sat%0d_en", n),     s_dump_en,     1);
      check($sformatf("sat%0d_frames", n), s_dump_frames, (n - 1 > 15) ? 15 : n - 1);
    end

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 199) == 0);
      rearm = ($urandom_range(0, 19) == 0);
      vs    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) downloading = ~downloading;
      case ($urandom_range(0, 3))
        0:       start_frame = e_cnt;
        1:       start_frame = e_cnt + 32'd1;
        2:       start_frame = e_cnt + 32'd2;
        default: start_frame = 32'($urandom_range(0, 40));
      endcase
      if ($urandom_range(0, 15) == 0) frame_len = 16'($urandom_range(0, 5));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jtframe_dump_trigger.md
Name: jtframe_dump_trigger

Overview:
- Synthesizable producer side of the simulation dump hook.
- Counts video frames from the falling edge of vertical sync and tracks the end of a ROM download.
- Drives a registered dump-window enable with start-frame and length control.
- Sits in the game top next to the video timing block; its frame_cnt and dump_en feed the dump controller and on-screen debug.

Parameters:
- CNTW, 32, frame counter width.
- LENW, 16, dump-length counter width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- vs  in  1  vertical sync (synchronous to clk); a frame boundary is a 1→0 transition
- downloading  in  1  ROM download in progress
- start_frame  in  CNTW  frame number that opens the window; compared live while ARMED
- frame_len  in  LENW  window length in frames; 0 = unlimited; latched on entering ACTIVE
- rearm  in  1  single-cycle pulse that returns the block to ARMED
- frame_cnt  out  CNTW  frames seen since reset
- frame_pulse  out  1  one-cycle strobe, coincident with each frame_cnt update
- dl_done  out  1  one-cycle strobe on the falling edge of downloading
- dump_en  out  1  dump window open
- dump_frames  out  LENW  frames elapsed inside the current window

Behaviour:
- Reset values: frame_cnt=0, frame_pulse=0, dl_done=0, dump_en=0, dump_frames=0, state=ARMED; edge registers vs_l=0 and dl_l=0, so reset release never produces a spurious edge.
- Edge detect: fall = vs_l & ~vs; dl_fall = dl_l & ~downloading. Every output is registered, so an edge detected in cycle N appears on the outputs in cycle N+1 (latency 1).
- Frame counting: on fall, frame_cnt <= frame_cnt+1, wrapping from 2^CNTW-1 to 0, and frame_pulse=1 for one cycle.
- States: ARMED, ACTIVE, DONE.
  - ARMED→ACTIVE: on fall when the pre-increment frame_cnt == start_frame. dump_en rises in the same cycle as that frame_pulse; dump_frames=0; frame_len is latched.
  - ACTIVE: each fall increments dump_frames. When the latched length is nonzero and dump_frames+1 == length, go to DONE and drop dump_en together with that frame_pulse. dump_frames saturates at 2^LENW-1 when the length is 0.
  - DONE: dump_en=0; dump_frames holds its value.
  - rearm from any state → ARMED, dump_en=0, dump_frames=0.
- rearm and fall in the same cycle: rearm wins. frame_cnt still increments, but no ARMED→ACTIVE compare happens that cycle.
- Start already passed: no trigger until frame_cnt wraps around to start_frame.
- rst asserted mid-window: immediate return to reset values; dump_en is low on the next cycle.
- dl_done: pulses on dl_fall regardless of state.

Optional Feature:
- Macro: JTFRAME_DUMP_AFTER_DL_EN.
- Defined:
  - While downloading=1, frame_cnt is held at 0, state is forced to ARMED and dump_en=0.
  - On dl_fall, frame_cnt clears to 0 and a dl_seen flag sets.
  - ARMED→ACTIVE additionally requires dl_seen; dl_seen clears only on rst.
- Undefined: downloading only drives dl_done.

Decomposition:
- Package jtframe_dump_pkg holds the state enum (ARMED, ACTIVE, DONE) and the default CNTW/LENW constants.
- One sub-module, jtframe_edge: registered fall/rise detector with synchronous reset, instantiated for vs and for downloading.

Test Plan:
- rst 4 cycles, then 5 vs falls → frame_cnt=5 and five single-cycle frame_pulse strobes, each one cycle after its fall; no pulse at reset release.
- start_frame=3, frame_len=2 → dump_en rises with the 4th frame_pulse (frame_cnt 3→4), falls with the 6th, state DONE, dump_frames=2.
- frame_len=0, start_frame=0 → dump_en rises on the first fall and stays high for 70000 frames; dump_frames saturates at 65535.
- In DONE, rearm and fall in the same cycle with start_frame=frame_cnt → frame_cnt increments, dump_en stays 0; next matching wrap or start change triggers normally.
- rst pulse while dump_en=1 at frame 10 → next cycle all outputs 0, state ARMED.
- With JTFRAME_DUMP_AFTER_DL_EN: 3 vs falls with downloading=1 → frame_cnt stays 0; downloading falls → dl_done pulse, frame_cnt=0; start_frame=0 → dump_en rises on the next fall.
